dc_ex_stage_reg: RTL and testbench

Parametrised decode-to-execute pipeline register for the RV32 5-stage core. It carries the instruction word, PC and `NUM_OPS` operand values, each `XLEN` bits wide, from decode to execute. It tracks a valid bit, so a bubble or flushed slot becomes a NOP. While the stage is stalled, it accepts per-operand forwarding overrides so that held operands pick up late write-back results.

---
 rtl/dc_ex_stage_reg.sv | 94 +++++++++
 tb/tb_dc_ex_stage_reg.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dc_ex_stage_reg.sv
// Decode-to-execute pipeline register: valid/inst/pc/operands, flush to NOP, stall with per-operand forwarding.
// Optional held-cycle counter enabled by defining DC_EX_STALL_CNT_EN.
module dc_ex_stage_reg #(
  parameter int                 XLEN        = 32,
  parameter int                 NUM_OPS     = 2,
  parameter logic [XLEN-1:0]    RESET_PC    = '0,
  parameter logic [31:0]        NOP_INST    = 32'h0000_0013,
  parameter int                 STALL_CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    in_valid,
  input  logic [31:0]             in_inst,
  input  logic [XLEN-1:0]         in_pc,
  input  logic [NUM_OPS*XLEN-1:0] in_ops,
  input  logic                    stall,
  input  logic                    flush,
  input  logic [NUM_OPS-1:0]      fwd_en,
  input  logic [NUM_OPS*XLEN-1:0] fwd_data,
  output logic                    out_valid,
  output logic [31:0]             out_inst,
  output logic [XLEN-1:0]         out_pc,
  output logic [NUM_OPS*XLEN-1:0] out_ops
`ifdef DC_EX_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0]  held_cycles
`endif
);

  logic            valid_reg;
  logic [31:0]     inst_reg;
  logic [XLEN-1:0] pc_reg;

  // The stage advances on the falling clock edge.
  always_ff @(negedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_reg <= 1'b0;
      inst_reg  <= NOP_INST;
      pc_reg    <= RESET_PC;
    end else if (flush) begin
      valid_reg <= 1'b0;
      inst_reg  <= NOP_INST;
    end else if (!stall) begin
      valid_reg <= in_valid;
      pc_reg    <= in_pc;
      inst_reg  <= in_valid ? in_inst : NOP_INST;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OPS; gi = gi + 1) begin : g_op
      logic [XLEN-1:0] op_reg;

      // Forwards only land in a real held instruction; bubbles keep zero operands.
      always_ff @(negedge clk or negedge resetn) begin
        if (!resetn) begin
          op_reg <= '0;
        end else if (flush) begin
          op_reg <= '0;
        end else if (stall) begin
          if (fwd_en[gi] && valid_reg)
            op_reg <= fwd_data[gi*XLEN +: XLEN];
        end else begin
          op_reg <= in_valid ? in_ops[gi*XLEN +: XLEN] : '0;
        end
      end

      assign out_ops[gi*XLEN +: XLEN] = op_reg;
    end
  endgenerate

  assign out_valid = valid_reg;
  assign out_inst  = inst_reg;
  assign out_pc    = pc_reg;

`ifdef DC_EX_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] held_reg;

  // Saturating count of edges a valid instruction sits stalled here.
  always_ff @(negedge clk or negedge resetn) begin
    if (!resetn) begin
      held_reg <= '0;
    end else if (flush || !stall) begin
      held_reg <= '0;
    end else if (valid_reg && (held_reg != {STALL_CNT_W{1'b1}})) begin
      held_reg <= held_reg + STALL_CNT_W'(1);
    end
  end

  assign held_cycles = held_reg;
`endif

endmodule

// File: tb/tb_dc_ex_stage_reg.sv
// Self-checking bench for dc_ex_stage_reg: directed vectors, a per-edge reference model and literal spot checks.
module tb_dc_ex_stage_reg;
  localparam int XLEN = 32;
  localparam int NOPS = 2;
  localparam int CW   = 2;

  logic              clk = 1'b0;
  logic              resetn;
  logic              in_valid;
  logic [31:0]       in_inst;
  logic [XLEN-1:0]   in_pc;
  logic [NOPS*XLEN-1:0] in_ops;
  logic              stall, flush;
  logic [NOPS-1:0]   fwd_en;
  logic [NOPS*XLEN-1:0] fwd_data;
  logic              out_valid;
  logic [31:0]       out_inst;
  logic [XLEN-1:0]   out_pc;
  logic [NOPS*XLEN-1:0] out_ops;
`ifdef DC_EX_STALL_CNT_EN
  logic [CW-1:0]     held_cycles;
`endif

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  dc_ex_stage_reg #(
    .XLEN(XLEN), .NUM_OPS(NOPS), .RESET_PC('0), .NOP_INST(32'h13), .STALL_CNT_W(CW)
  ) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc),
    .in_ops(in_ops), .stall(stall), .flush(flush), .fwd_en(fwd_en), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc), .out_ops(out_ops)
`ifdef DC_EX_STALL_CNT_EN
    , .held_cycles(held_cycles)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what execute must see, expressed as the stage's per-edge rules.
  bit        m_valid;
  bit [31:0] m_inst;
  bit [31:0] m_pc;
  bit [31:0] m_ops [NOPS];
  int        m_held;

  always @(negedge clk or negedge resetn) begin
    if (!resetn) begin
      m_valid = 0; m_inst = 32'h13; m_pc = 0; m_held = 0;
      foreach (m_ops[i]) m_ops[i] = 0;
    end else if (flush) begin
      m_valid = 0; m_inst = 32'h13; m_held = 0;
      foreach (m_ops[i]) m_ops[i] = 0;
    end else if (stall) begin
      if (m_valid) begin
        for (int i = 0; i < NOPS; i++)
          if (fwd_en[i]) m_ops[i] = fwd_data[i*XLEN +: XLEN];
        if (m_held < (1 << CW) - 1) m_held = m_held + 1;
      end
    end else begin
      m_valid = in_valid;
      m_pc    = in_pc;
      m_inst  = in_valid ? in_inst : 32'h13;
      for (int i = 0; i < NOPS; i++) m_ops[i] = in_valid ? in_ops[i*XLEN +: XLEN] : 32'h0;
      m_held  = 0;
    end
  end

  always @(posedge clk) begin
    if (cmp_en) begin
      chk("model_valid", 64'(out_valid), 64'(m_valid));
      chk("model_inst", 64'(out_inst), 64'(m_inst));
      chk("model_pc", 64'(out_pc), 64'(m_pc));
      for (int i = 0; i < NOPS; i++) chk($sformatf("model_op%0d", i), 64'(out_ops[i*XLEN +: XLEN]), 64'(m_ops[i]));
`ifdef DC_EX_STALL_CNT_EN
      chk("model_held", 64'(held_cycles), 64'(m_held));
`endif
    end
  end

  task automatic cyc();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic [31:0] op1, input logic [31:0] op0);
    in_valid = v; in_inst = inst; in_pc = pc; in_ops = {op1, op0};
  endtask

  task automatic show(input string tag);
    $display("[%0t] %s valid=%0b inst=%h pc=%h ops=%h", $time, tag, out_valid, out_inst, out_pc, out_ops);
  endtask

  initial begin
    resetn = 1'b0; stall = 0; flush = 0; fwd_en = '0; fwd_data = '0;
    drive(0, 32'h0, 32'h0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    show("reset");
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_inst", 64'(out_inst), 64'h13);
    chk("rst_pc", 64'(out_pc), 64'h0);
    chk("rst_ops", 64'(out_ops), 64'h0);
    cmp_en = 1'b1;

    resetn = 1'b1;
    drive(1, 32'h00500093, 32'h40, 32'h2, 32'h1);
    cyc(); show("load");
    chk("load_valid", 64'(out_valid), 64'd1);
    chk("load_inst", 64'(out_inst), 64'h00500093);
    chk("load_pc", 64'(out_pc), 64'h40);
    chk("load_ops", 64'(out_ops), 64'h00000002_00000001);

    drive(0, 32'hDEADBEEF, 32'h44, 32'h77, 32'h66);
    cyc(); show("bubble");
    chk("bub_valid", 64'(out_valid), 64'd0);
    chk("bub_inst", 64'(out_inst), 64'h13);
    chk("bub_ops", 64'(out_ops), 64'h0);
    chk("bub_pc", 64'(out_pc), 64'h44);

    drive(1, 32'h00208133, 32'h48, 32'h22, 32'h11);
    cyc(); show("load2");
    drive(0, 32'hFFFF_FFFF, 32'h99, 32'h5, 32'h5);
    stall = 1;
    cyc(); show("stall1");
    fwd_en = 2'b10; fwd_data = {32'hAA, 32'h55};
    cyc(); show("stall2");
    chk("fwd_op1", 64'(out_ops[32 +: 32]), 64'hAA);
    chk("fwd_op0", 64'(out_ops[0 +: 32]), 64'h11);
    fwd_en = 2'b00; fwd_data = {32'hBB, 32'hCC};
    cyc(); show("stall3");
    chk("stall_inst", 64'(out_inst), 64'h00208133);
    chk("stall_pc", 64'(out_pc), 64'h48);
    chk("stall_ops", 64'(out_ops), 64'h000000AA_00000011);
`ifdef DC_EX_STALL_CNT_EN
    chk("held_3", 64'(held_cycles), 64'd3);
`endif
    stall = 0;
    drive(1, 32'h00300193, 32'h4C, 32'h44, 32'h33);
    cyc(); show("release");
    chk("rel_inst", 64'(out_inst), 64'h00300193);
`ifdef DC_EX_STALL_CNT_EN
    chk("held_clr", 64'(held_cycles), 64'd0);
`endif

    stall = 1; flush = 1; fwd_en = 2'b11; fwd_data = {32'hEE, 32'hDD};
    cyc(); show("flush");
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_inst", 64'(out_inst), 64'h13);
    chk("fl_ops", 64'(out_ops), 64'h0);
    chk("fl_pc", 64'(out_pc), 64'h4C);

    flush = 0;
    cyc(); show("fwd_bubble");
    chk("fwdbub_ops", 64'(out_ops), 64'h0);

    stall = 0; fwd_en = 2'b00;
    drive(1, 32'h00400213, 32'h50, 32'h8, 32'h7);
    cyc(); show("load3");
    stall = 1; fwd_en = 2'b11; fwd_data = {32'h1234, 32'h5678};
    cyc(); show("fwd_both");
    chk("fwd_both", 64'(out_ops), 64'h00001234_00005678);
    fwd_en = 2'b00;
    repeat (5) cyc();
    show("sat");
`ifdef DC_EX_STALL_CNT_EN
    chk("held_sat", 64'(held_cycles), 64'd3);
`endif

    #2 resetn = 1'b0;
    #1; show("async_rst");
    chk("ar_valid", 64'(out_valid), 64'd0);
    chk("ar_inst", 64'(out_inst), 64'h13);
    chk("ar_pc", 64'(out_pc), 64'h0);
    chk("ar_ops", 64'(out_ops), 64'h0);
    @(posedge clk); #1;
    resetn = 1'b1; stall = 0;

    for (int n = 0; n < 40; n++) begin
      drive(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, $urandom);
      stall = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 7) == 0);
      fwd_en = 2'($urandom);
      fwd_data = {$urandom, $urandom};
      cyc(); show("rand");
    end

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
